// File: rtl/poly_op_sequencer.sv
// Issue/drain sequencer for NTT, INTT and pointwise-multiply passes.
// Drives stage/idx, bank read enables and latency-matched write enables.
module poly_op_sequencer #(
  parameter int LOG_N   = 9,
  parameter int LOG_BFU = 2,
  parameter int BF_LAT  = 10,
  parameter int PWM_LAT = 10
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     start,
  input  logic [1:0]               conf,
  input  logic                     abort,
  output logic                     busy,
  output logic                     done,
  output logic                     op_err,
  output logic [$clog2(LOG_N):0]   stage,
  output logic [LOG_N-LOG_BFU-1:0] idx,
  output logic                     intt_mode,
  output logic                     ren_a,
  output logic                     ren_b,
  output logic                     wen_a,
  output logic                     wen_b
);

  localparam int SW   = $clog2(LOG_N) + 1;
  localparam int IW   = LOG_N - LOG_BFU;
  localparam int MAXL = (BF_LAT > PWM_LAT) ? BF_LAT : PWM_LAT;
  localparam int SHW  = MAXL + 1;
  localparam int LW   = $clog2(MAXL + 1);

  localparam logic [SW-1:0] S_TOP  = SW'(LOG_N - 1);
  localparam logic [IW-1:0] C_LAST = IW'((1 << (IW - 1)) - 1);
  localparam logic [IW-1:0] P_LAST = '1;
  localparam logic [LW-1:0] L_BF   = LW'(BF_LAT);
  localparam logic [LW-1:0] L_PWM  = LW'(PWM_LAT);

  localparam logic [1:0] C_NTT  = 2'b01;
  localparam logic [1:0] C_PWM  = 2'b10;
  localparam logic [1:0] C_INTT = 2'b11;

  typedef enum logic [2:0] {
    S_IDLE,
    S_NTT,
    S_INTT,
    S_PWM,
    S_DRAIN
  } state_t;

  state_t r_state;
  state_t w_next;

  logic [1:0]     r_conf;
  logic [SW-1:0]  r_stage;
  logic [IW-1:0]  r_idx;
  logic [LW-1:0]  r_lat;
  logic [LW-1:0]  r_dcnt;
  logic [SHW-1:0] r_sh_v;
  logic [SHW-1:0] r_sh_s;
  logic           r_done;
  logic           r_op_err;

  logic          w_issue;
  logic          w_last;
  logic          w_fin;
  logic          w_abort;
  logic          w_accept;
  logic          w_rsel;
  logic [SW-1:0] w_home;
  logic [SW-1:0] w_init;

  assign w_issue = (r_state == S_NTT) ||
                   (r_state == S_INTT) ||
                   (r_state == S_PWM);
  assign w_abort = abort && (r_state != S_IDLE);
  assign w_accept = (r_state == S_IDLE) && (w_next != S_IDLE);

  assign w_home = (r_conf == C_INTT) ? S_TOP : '0;
  assign w_init = (conf == C_INTT) ? S_TOP : '0;

  assign intt_mode = (r_conf == C_INTT) && (r_state != S_IDLE);
  assign w_rsel = (r_state == S_PWM) ? 1'b0 : (r_stage[0] ^ intt_mode);

  always_comb begin
    w_last = 1'b0;
    unique case (r_state)
      S_NTT:   w_last = (r_stage == S_TOP) && (r_idx == C_LAST);
      S_INTT:  w_last = (r_stage == '0) && (r_idx == C_LAST);
      S_PWM:   w_last = (r_idx == P_LAST);
      default: w_last = 1'b0;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= S_IDLE;
    else        r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    w_fin  = 1'b0;
    unique case (r_state)
      S_IDLE: begin
        if (start && !abort) begin
          unique case (1'b1)
            (conf == C_NTT):  w_next = S_NTT;
            (conf == C_INTT): w_next = S_INTT;
            (conf == C_PWM):  w_next = S_PWM;
            default:          w_next = S_IDLE;
          endcase
        end
      end
      S_NTT, S_INTT, S_PWM: begin
        if (w_last) w_next = S_DRAIN;
      end
      S_DRAIN: begin
        if (r_dcnt == r_lat) begin
          w_next = S_IDLE;
          w_fin  = 1'b1;
        end
      end
      default: w_next = S_IDLE;
    endcase
    if (w_abort) begin
      w_next = S_IDLE;
      w_fin  = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_conf   <= '0;
      r_stage  <= '0;
      r_idx    <= '0;
      r_lat    <= '0;
      r_done   <= 1'b0;
      r_op_err <= 1'b0;
    end else begin
      r_done   <= w_fin;
      r_op_err <= (r_state == S_IDLE) && start &&
                  !abort && (conf == 2'b00);
      if (w_accept) begin
        r_conf  <= conf;
        r_lat   <= (conf == C_PWM) ? L_PWM : L_BF;
        r_stage <= w_init;
        r_idx   <= '0;
      end else if ((r_state == S_IDLE) || (w_next == S_IDLE)) begin
        r_stage <= w_home;
        r_idx   <= '0;
      end else if (w_issue) begin
        if (w_last) begin
          r_stage <= w_home;
          r_idx   <= '0;
        end else if (r_state == S_PWM) begin
          r_idx <= r_idx + IW'(1);
        end else if (r_idx == C_LAST) begin
          r_idx <= '0;
          if (r_state == S_INTT) r_stage <= r_stage - SW'(1);
          else                   r_stage <= r_stage + SW'(1);
        end else begin
          r_idx <= r_idx + IW'(1);
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                   r_dcnt <= '0;
    else if (r_state == S_DRAIN)  r_dcnt <= r_dcnt + LW'(1);
    else                          r_dcnt <= '0;
  end

  // Nothing is in flight once back in IDLE, so the delay line is flushed there.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_sh_v <= '0;
      r_sh_s <= '0;
    end else if (w_abort || (r_state == S_IDLE)) begin
      r_sh_v <= '0;
      r_sh_s <= '0;
    end else begin
      r_sh_v <= {r_sh_v[SHW-2:0], w_issue};
      r_sh_s <= {r_sh_s[SHW-2:0], w_rsel};
    end
  end

  assign busy   = (r_state != S_IDLE);
  assign done   = r_done;
  assign op_err = r_op_err;
  assign stage  = r_stage;
  assign idx    = r_idx;
  assign ren_a  = w_issue && !w_rsel;
  assign ren_b  = w_issue && w_rsel;
  assign wen_a  = r_sh_v[r_lat] && r_sh_s[r_lat];
  assign wen_b  = r_sh_v[r_lat] && !r_sh_s[r_lat];

endmodule

// File: tb/tb_poly_op_sequencer.sv
// Directed bench for poly_op_sequencer: default and small-parameter
// instances, with hand-derived timing and issue-sequence expectations.
module tb_poly_op_sequencer;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       start;
  logic       abort;
  logic [1:0] conf;
  logic       sel;

  always #5 clk = ~clk;

  logic       d_busy, d_done, d_err, d_intt;
  logic       d_ren_a, d_ren_b, d_wen_a, d_wen_b;
  logic [4:0] d_stage;
  logic [6:0] d_idx;

  logic       m_busy, m_done, m_err, m_intt;
  logic       m_ren_a, m_ren_b, m_wen_a, m_wen_b;
  logic [2:0] m_stage;
  logic [2:0] m_idx;

  logic d_start, m_start, d_abort, m_abort;
  assign d_start = start && !sel;
  assign m_start = start && sel;
  assign d_abort = abort && !sel;
  assign m_abort = abort && sel;

  poly_op_sequencer u_dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (d_start),
    .conf      (conf),
    .abort     (d_abort),
    .busy      (d_busy),
    .done      (d_done),
    .op_err    (d_err),
    .stage     (d_stage),
    .idx       (d_idx),
    .intt_mode (d_intt),
    .ren_a     (d_ren_a),
    .ren_b     (d_ren_b),
    .wen_a     (d_wen_a),
    .wen_b     (d_wen_b)
  );

  poly_op_sequencer #(
    .LOG_N   (4),
    .LOG_BFU (1),
    .BF_LAT  (3),
    .PWM_LAT (3)
  ) u_mini (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (m_start),
    .conf      (conf),
    .abort     (m_abort),
    .busy      (m_busy),
    .done      (m_done),
    .op_err    (m_err),
    .stage     (m_stage),
    .idx       (m_idx),
    .intt_mode (m_intt),
    .ren_a     (m_ren_a),
    .ren_b     (m_ren_b),
    .wen_a     (m_wen_a),
    .wen_b     (m_wen_b)
  );

  logic o_busy, o_done, o_err, o_intt;
  logic o_ren_a, o_ren_b, o_wen_a, o_wen_b;
  int   o_stage, o_idx;

  always_comb begin
    o_busy  = sel ? m_busy  : d_busy;
    o_done  = sel ? m_done  : d_done;
    o_err   = sel ? m_err   : d_err;
    o_intt  = sel ? m_intt  : d_intt;
    o_ren_a = sel ? m_ren_a : d_ren_a;
    o_ren_b = sel ? m_ren_b : d_ren_b;
    o_wen_a = sel ? m_wen_a : d_wen_a;
    o_wen_b = sel ? m_wen_b : d_wen_b;
    o_stage = sel ? int'(m_stage) : int'(d_stage);
    o_idx   = sel ? int'(m_idx)   : int'(d_idx);
  end

  int n_tests = 0;
  int n_fail  = 0;

  task automatic chk(input string tag, input int got, input int exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  int n_issue, n_busy, n_busy_gap, n_seq_bad;
  int n_rena, n_renb, n_wena, n_wenb, n_err, n_done, n_intt;
  int t_ren0, t_wen0, t_wen_last, t_done, done_busy;

  task automatic clear_stats();
    n_issue = 0; n_busy = 0; n_busy_gap = 0; n_seq_bad = 0;
    n_rena = 0; n_renb = 0; n_wena = 0; n_wenb = 0;
    n_err = 0; n_done = 0; n_intt = 0;
    t_ren0 = -1; t_wen0 = -1; t_wen_last = -1;
    t_done = -1; done_busy = -1;
  endtask

  // Start an op, then watch a fixed window of edges against a reference
  // model of the issue sequence (stage, idx, read bank, intt_mode).
  task automatic run_op(input logic use_mini, input logic [1:0] c,
                        input int logn, input int cc, input int limit);
    int k, es, ei, erb;
    sel = use_mini;
    clear_stats();
    @(posedge clk); #1;
    start = 1'b1;
    conf  = c;
    for (int t = 1; t <= limit; t++) begin
      @(posedge clk); #1;
      start = 1'b0;
      if (o_busy) n_busy++;
      if (o_ren_a) n_rena++;
      if (o_ren_b) n_renb++;
      if (o_ren_a || o_ren_b) begin
        k = n_issue;
        n_issue++;
        if (t_ren0 < 0) t_ren0 = t;
        if (c == 2'b10) begin
          es = 0; ei = k; erb = 0;
        end else begin
          es = (c == 2'b11) ? (logn - 1 - k / cc) : (k / cc);
          ei = k % cc;
          erb = (es % 2) ^ ((c == 2'b11) ? 1 : 0);
        end
        if (o_stage != es || o_idx != ei) n_seq_bad++;
        if (int'(o_ren_b) != erb || int'(o_ren_a) == erb) n_seq_bad++;
        if (!o_busy) n_busy_gap++;
        if (o_intt) n_intt++;
      end
      if (o_wen_a) n_wena++;
      if (o_wen_b) n_wenb++;
      if (o_wen_a || o_wen_b) begin
        if (t_wen0 < 0) t_wen0 = t;
        t_wen_last = t;
      end
      if (o_err) n_err++;
      if (o_done) begin
        n_done++;
        if (t_done < 0) begin
          t_done = t;
          done_busy = int'(o_busy);
        end
      end
    end
  endtask

  int ab_done, ab_wen, ab_busy, cnt;

  initial begin
    rst_n = 1'b0;
    start = 1'b0;
    abort = 1'b0;
    conf  = 2'b00;
    sel   = 1'b0;
    #12;
    chk("rst_ctrl", int'({d_busy, d_done, d_err, d_intt}), 0);
    chk("rst_en", int'({d_ren_a, d_ren_b, d_wen_a, d_wen_b}), 0);
    chk("rst_cnt", int'({d_stage, d_idx}), 0);
    chk("rst_mini", int'({m_busy, m_ren_a, m_wen_b, m_stage}), 0);
    @(posedge clk); #1;
    rst_n = 1'b1;

    // NTT, defaults
    run_op(1'b0, 2'b01, 9, 64, 620);
    chk("ntt_issue", n_issue, 576);
    chk("ntt_seq", n_seq_bad, 0);
    chk("ntt_busy_gap", n_busy_gap, 0);
    chk("ntt_busy_cyc", n_busy, 587);
    chk("ntt_done_t", t_done, 588);
    chk("ntt_done_n", n_done, 1);
    chk("ntt_done_busy", done_busy, 0);
    chk("ntt_wen_lag", t_wen0 - t_ren0, 11);
    chk("ntt_wen_tot", n_wena + n_wenb, 576);
    chk("ntt_wen_last", t_wen_last, 587);
    chk("ntt_idle_stage", o_stage, 0);

    // INTT, defaults
    run_op(1'b0, 2'b11, 9, 64, 620);
    chk("intt_issue", n_issue, 576);
    chk("intt_seq", n_seq_bad, 0);
    chk("intt_first_renb", n_renb, 320);
    chk("intt_mode_cyc", n_intt, 576);
    chk("intt_done_t", t_done, 588);
    chk("intt_idle_stage", o_stage, 8);
    chk("intt_idle_idx", o_idx, 0);
    chk("intt_idle_mode", int'(o_intt), 0);

    // PWM, defaults
    run_op(1'b0, 2'b10, 9, 64, 170);
    chk("pwm_issue", n_issue, 128);
    chk("pwm_rena", n_rena, 128);
    chk("pwm_seq", n_seq_bad, 0);
    chk("pwm_wenb", n_wenb, 128);
    chk("pwm_wena", n_wena, 0);
    chk("pwm_done_t", t_done, 140);
    chk("pwm_done_n", n_done, 1);

    // invalid conf
    run_op(1'b0, 2'b00, 9, 64, 30);
    chk("bad_err", n_err, 1);
    chk("bad_busy", n_busy, 0);
    chk("bad_ren", n_rena + n_renb, 0);
    chk("bad_wen", n_wena + n_wenb, 0);
    chk("bad_done", n_done, 0);

    // abort mid-NTT, restart as PWM, spurious INTT start while busy
    sel = 1'b0;
    clear_stats();
    ab_done = 0; ab_wen = 0; ab_busy = -1;
    @(posedge clk); #1;
    start = 1'b1;
    conf  = 2'b01;
    for (int t = 1; t <= 400; t++) begin
      @(posedge clk); #1;
      start = 1'b0;
      abort = 1'b0;
      if (t <= 103 && o_done) ab_done++;
      if (t >= 101 && t <= 114 && (o_wen_a || o_wen_b)) ab_wen++;
      if (t == 101) ab_busy = int'(o_busy);
      if (t > 103 && o_ren_a) n_rena++;
      if (t > 103 && o_ren_b) n_renb++;
      if (o_intt) n_intt++;
      if (o_err) n_err++;
      if (o_done) begin
        n_done++;
        if (t_done < 0) t_done = t;
      end
      if (t == 100) abort = 1'b1;
      if (t == 103) begin
        start = 1'b1;
        conf  = 2'b10;
      end
      if (t == 150) begin
        start = 1'b1;
        conf  = 2'b11;
      end
    end
    chk("abort_no_done", ab_done, 0);
    chk("abort_no_wen", ab_wen, 0);
    chk("abort_busy", ab_busy, 0);
    chk("restart_done_t", t_done, 243);
    chk("restart_done_n", n_done, 1);
    chk("restart_rena", n_rena, 128);
    chk("ignored_start", n_renb + n_intt + n_err, 0);

    // start together with abort in IDLE
    @(posedge clk); #1;
    start = 1'b1;
    abort = 1'b1;
    conf  = 2'b01;
    cnt = 0;
    for (int t = 0; t < 5; t++) begin
      @(posedge clk); #1;
      start = 1'b0;
      abort = 1'b0;
      if (o_busy || o_ren_a || o_err) cnt++;
    end
    chk("start_abort_idle", cnt, 0);

    // small parameter set
    run_op(1'b1, 2'b01, 4, 4, 40);
    chk("mini_issue", n_issue, 16);
    chk("mini_seq_bank", n_seq_bad, 0);
    chk("mini_done_t", t_done, 21);
    chk("mini_wen_lag", t_wen0 - t_ren0, 4);
    chk("mini_wen_last", t_wen_last, 20);

    // asynchronous reset mid-operation
    sel = 1'b0;
    @(posedge clk); #1;
    start = 1'b1;
    conf  = 2'b01;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (50) @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    chk("arst_out", int'({o_busy, o_ren_a, o_ren_b, o_wen_a, o_wen_b}), 0);
    chk("arst_cnt", o_stage + o_idx, 0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    cnt = 0;
    for (int t = 0; t < 700; t++) begin
      @(posedge clk); #1;
      if (o_done || o_busy || o_wen_a || o_wen_b) cnt++;
    end
    chk("arst_quiet", cnt, 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
